// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM states,
// access-size encodings and owner tags.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR_D = 3'd1,
    ST_ADDR_I = 3'd2,
    ST_WAIT_D = 3'd3,
    ST_WAIT_I = 3'd4
  } arb_state_e;

  localparam logic [1:0] SIZE_1B = 2'd0;
  localparam logic [1:0] SIZE_2B = 2'd1;
  localparam logic [1:0] SIZE_4B = 2'd2;

  localparam logic OWNER_D = 1'b0;
  localparam logic OWNER_I = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way round-robin grant: a lone requester always wins, and a tie goes to
// whichever side did not own the last completed transaction.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic req_d,
  input  logic req_i,
  input  logic last_owner,
  output logic gnt_d,
  output logic gnt_i
);

  assign gnt_d = req_d & (~req_i | (last_owner == OWNER_I));
  assign gnt_i = req_i & (~req_d | (last_owner == OWNER_D));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one shared
// memory port, keeping at most one transaction outstanding.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_state_e r_state;
  arb_state_e w_next_state;
  logic       r_last_owner;
  logic       w_next_owner;
  logic       w_gnt_d;
  logic       w_gnt_i;

  mem_arb_pick u_pick (
    .req_d      (data_req),
    .req_i      (inst_req),
    .last_owner (r_last_owner),
    .gnt_d      (w_gnt_d),
    .gnt_i      (w_gnt_i)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_last_owner <= OWNER_I;
    end else begin
      r_state      <= w_next_state;
      r_last_owner <= w_next_owner;
    end
  end

  // Handshakes pass straight through from the shared port to the current owner.
  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_last_owner;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    rdata        = 32'h0000_0000;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = SIZE_1B;
    mem_wstrb    = 4'b0000;
    mem_addr     = 32'h0000_0000;
    mem_wdata    = 32'h0000_0000;

    case (r_state)
      ST_IDLE: begin
        if (w_gnt_d) begin
          w_next_state = ST_ADDR_D;
        end else if (w_gnt_i) begin
          w_next_state = ST_ADDR_I;
        end else begin
          w_next_state = ST_IDLE;
        end
      end

      ST_ADDR_D: begin
        mem_req   = data_req;
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        if (!data_req) begin
          w_next_state = ST_IDLE;
        end else if (mem_addr_ok) begin
          data_addr_ok = 1'b1;
          w_next_state = ST_WAIT_D;
        end else begin
          w_next_state = ST_ADDR_D;
        end
      end

      ST_ADDR_I: begin
        mem_req  = inst_req;
        mem_size = SIZE_4B;
        mem_addr = inst_addr;
        if (!inst_req) begin
          w_next_state = ST_IDLE;
        end else if (mem_addr_ok) begin
          inst_addr_ok = 1'b1;
          w_next_state = ST_WAIT_I;
        end else begin
          w_next_state = ST_ADDR_I;
        end
      end

      ST_WAIT_D: begin
        if (mem_data_ok) begin
          data_data_ok = 1'b1;
          rdata        = mem_rdata;
          w_next_owner = OWNER_D;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT_D;
        end
      end

      ST_WAIT_I: begin
        if (mem_data_ok) begin
          inst_data_ok = 1'b1;
          rdata        = mem_rdata;
          w_next_owner = OWNER_I;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT_I;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected handshakes,
// a negedge monitor pops and compares them as the DUT strobes.
module tb_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic [107:0] all_out;

  mem_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .rdata        (rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  assign all_out = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, rdata,
                    mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 inst_addr_ok, 1 inst_data_ok, 2 data_addr_ok, 3 data_data_ok
  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic check_pop(input int kind);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_strobe: kind %0d at cycle %0d, nothing expected", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          ((kind == 1 || kind == 3) && rdata !== e.data)) begin
        n_err++;
        $display("FAIL strobe: got kind %0d cycle %0d rdata %08h, expected kind %0d cycle %0d rdata %08h",
                 kind, cyc, rdata, e.kind, e.cyc, e.data);
      end
    end
  endtask

  // Monitor: drop stale expectations, match strobes, and police rdata when idle.
  always @(negedge clk) begin : monitor
    logic [3:0] strobes;
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL missed_strobe: kind %0d expected at cycle %0d never seen", exp_q[0].kind, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    strobes = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    for (int k = 0; k < 4; k++) begin
      if (strobes[3-k]) check_pop(k);
    end
    if (!inst_data_ok && !data_data_ok) chk("rdata_idle_zero", rdata, 32'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept the owner's request in the next cycle, then drop it in the WAIT cycle.
  task automatic addr_phase(input bit is_d);
    step();
    mem_addr_ok = 1'b1;
    push(is_d ? 2 : 0, 32'h0);
    @(negedge clk);
    chk("addr_mem_req", mem_req, 1'b1);
    if (is_d)
      chk("addr_fields_d", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata},
          {data_wr, data_size, data_wstrb, data_addr, data_wdata});
    else
      chk("addr_fields_i", {mem_wr, mem_size, mem_wstrb, mem_addr},
          {1'b0, 2'd2, 4'b0000, inst_addr});
    step();
    mem_addr_ok = 1'b0;
    if (is_d) data_req = 1'b0;
    else      inst_req = 1'b0;
  endtask

  // Wait n_wait cycles, return data, and leave the bench in the following IDLE cycle.
  task automatic data_phase(input bit is_d, input logic [31:0] rd, input int n_wait);
    for (int k = 0; k < n_wait; k++) begin
      @(negedge clk);
      chk("wait_mem_req", mem_req, 1'b0);
      step();
    end
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    push(is_d ? 3 : 1, rd);
    @(negedge clk);
    chk("data_mem_req", mem_req, 1'b0);
    step();
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  initial begin
    resetn      = 1'b0;
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd2;
    data_wstrb  = 4'b0000;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;

    @(negedge clk);
    chk("reset_outputs", all_out, 108'h0);
    step();
    resetn = 1'b1;

    // Tie from reset: data, inst, then data again, inst again.
    data_req  = 1'b1;
    inst_req  = 1'b1;
    data_addr = 32'h0000_0100;
    inst_addr = 32'h0000_4000;
    @(negedge clk);
    chk("idle_mem_req", mem_req, 1'b0);
    addr_phase(1'b1);
    data_phase(1'b1, 32'h1111_1111, 1);
    addr_phase(1'b0);
    data_phase(1'b0, 32'h2222_2222, 1);
    data_req = 1'b1;
    inst_req = 1'b1;
    addr_phase(1'b1);
    data_phase(1'b1, 32'h3333_3333, 1);
    addr_phase(1'b0);
    data_phase(1'b0, 32'h4444_4444, 0);

    // Lone load: addr_ok in cycle 2, data_ok in cycle 4.
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_size = 2'd2;
    data_addr = 32'h0000_1004;
    @(negedge clk);
    chk("load_idle_mem_req", mem_req, 1'b0);
    addr_phase(1'b1);
    data_phase(1'b1, 32'hDEAD_BEEF, 1);

    // Last owner was data, so a tie now goes to inst.
    data_req  = 1'b1;
    inst_req  = 1'b1;
    data_addr = 32'h0000_0200;
    inst_addr = 32'h0000_4008;
    addr_phase(1'b0);
    data_phase(1'b0, 32'h5555_5555, 1);
    addr_phase(1'b1);
    data_phase(1'b1, 32'h6666_6666, 1);

    // Byte store.
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd0;
    data_wstrb = 4'b0100;
    data_wdata = 32'h5A5A_5A5A;
    data_addr  = 32'h0000_2002;
    step();
    mem_addr_ok = 1'b1;
    push(2, 32'h0);
    @(negedge clk);
    chk("store_fields", {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata},
        {1'b1, 1'b1, 2'd0, 4'b0100, 32'h0000_2002, 32'h5A5A_5A5A});
    step();
    mem_addr_ok = 1'b0;
    data_req    = 1'b0;
    data_phase(1'b1, 32'h0, 2);
    data_wr    = 1'b0;
    data_size  = 2'd2;
    data_wstrb = 4'b0000;
    data_wdata = 32'h0;

    // Busy stall: inst raised during WAIT_D must wait, then be served.
    data_req  = 1'b1;
    data_addr = 32'h0000_0300;
    addr_phase(1'b1);
    inst_req  = 1'b1;
    inst_addr = 32'h0000_4010;
    data_phase(1'b1, 32'h7777_7777, 2);
    @(negedge clk);
    chk("stall_idle_mem_req", mem_req, 1'b0);
    addr_phase(1'b0);
    data_phase(1'b0, 32'h8888_8888, 1);

    // Spurious mem_data_ok in IDLE and in ADDR_I.
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hBADB_AD00;
    inst_req    = 1'b1;
    inst_addr   = 32'h0000_4020;
    @(negedge clk);
    chk("spur_idle_mem_req", mem_req, 1'b0);
    step();
    @(negedge clk);
    chk("spur_addr_i", {mem_req, mem_addr}, {1'b1, 32'h0000_4020});
    step();
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    @(negedge clk);
    chk("spur_state_hold", mem_req, 1'b1);
    addr_phase(1'b0);
    data_phase(1'b0, 32'h9999_9999, 1);

    // Reset while in WAIT_I, with a late mem_data_ok hanging around.
    inst_req  = 1'b1;
    inst_addr = 32'h0000_4030;
    addr_phase(1'b0);
    #1;
    resetn      = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hCAFE_F00D;
    #1;
    chk("reset_async_outputs", all_out, 108'h0);
    step();
    step();
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_mem_req", mem_req, 1'b0);
    step();
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_size   = 2'd2;
    data_addr   = 32'h0000_0500;
    addr_phase(1'b1);
    data_phase(1'b1, 32'h600D_F00D, 1);

    step();
    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have no parameters; widths are fixed (32-bit address/data).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 inst_req  input  1  fetch-side read request; held until inst_addr_ok.
REQ-006 inst_addr  input  32  fetch address.
REQ-007 inst_addr_ok  output  1  fetch request accepted.
REQ-008 inst_data_ok  output  1  fetch data valid on rdata.
REQ-009 data_req  input  1  load/store request; held until data_addr_ok.
REQ-010 data_wr  input  1  1 = store, 0 = load.
REQ-011 data_size  input  2  bytes to access: 0 = 1, 1 = 2, 2 = 4.
REQ-012 data_wstrb  input  4  store byte enables.
REQ-013 data_addr  input  32  load/store address.
REQ-014 data_wdata  input  32  store data, byte-replicated by the requester.
REQ-015 data_addr_ok  output  1  load/store request accepted.
REQ-016 data_data_ok  output  1  load data valid on rdata, or store complete.
REQ-017 rdata  output  32  read data, shared by both requesters, qualified by the x_data_ok strobes.
REQ-018 mem_req  output  1  shared-port request.
REQ-019 mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  output  1/2/4/32/32  shared-port request fields.
REQ-020 mem_addr_ok  input  1  shared port accepted the request.
REQ-021 mem_data_ok  input  1  shared port returned data or completed the write.
REQ-022 mem_rdata  input  32  shared-port read data.

Function
REQ-023 The FSM SHALL have the states IDLE, ADDR_D, ADDR_I, WAIT_D and WAIT_I.
REQ-024 At most one transaction SHALL be outstanding on the shared port at any time.
REQ-025 IDLE: with only data_req high -> ADDR_D; with only inst_req high -> ADDR_I; with neither high -> stay in IDLE.
REQ-026 IDLE, both requests high: the grant SHALL go to the requester that was not the owner of the last completed transaction (round-robin via a last_owner register).
REQ-027 IDLE SHALL drive mem_req = 0, so the minimum latency from req to mem_req is 1 cycle.
REQ-028 ADDR_x: mem_req = x_req and mem fields come from owner x; for the inst side, mem_wr = 0, mem_size = 2 and mem_wstrb = 0.
REQ-029 ADDR_x with mem_addr_ok = 1: x_addr_ok = 1 in the same cycle (combinational pass-through), and the next state is WAIT_x.
REQ-030 ADDR_x with x_req = 0 (requester withdrew): return to IDLE with no addr_ok and no last_owner update.
REQ-031 WAIT_x: mem_req = 0; when mem_data_ok = 1, x_data_ok = 1, rdata = mem_rdata, last_owner <= x and the next state is IDLE, all in the same cycle.
REQ-032 mem_data_ok SHALL be ignored outside the WAIT states, and mem_addr_ok SHALL be ignored outside the ADDR states.
REQ-033 The non-owner's addr_ok and data_ok SHALL remain 0 in every state.
REQ-034 rdata SHALL be 0 whenever no data_ok is asserted.
REQ-035 A request arriving while the arbiter is busy SHALL wait for IDLE and SHALL NOT be dropped.

Reset
REQ-036 On resetn low, the block SHALL set state = IDLE and last_owner = inst (data wins the first tie), and drive all outputs to 0, immediately and regardless of state.
REQ-037 A transaction in flight when reset is asserted SHALL be abandoned; any late mem_data_ok SHALL then fall under REQ-032.

Structure
REQ-038 A shared package SHALL hold the FSM state enum typedef and the size constants SIZE_1B = 0, SIZE_2B = 1, SIZE_4B = 2.
REQ-039 The 2-way round-robin grant selection SHALL be a sub-module named mem_arb_pick, with inputs req_d, req_i and last_owner and outputs gnt_d and gnt_i.
REQ-040 All other logic, including the FSM and the request mux, SHALL reside in mem_arbiter.

Verification
REQ-041 Lone load: data_req with data_wr = 0, size 2, addr 0x00001004; mem_addr_ok in cycle 2, mem_data_ok in cycle 4 with 0xDEADBEEF -> data_addr_ok in cycle 2, and data_data_ok with rdata = 0xDEADBEEF in cycle 4.
REQ-042 Simultaneous requests from reset: data served first, then inst; the next tie goes to data, so ownership strictly alternates.
REQ-043 Store: data_wr = 1, size 0, wstrb 0100, wdata 0x5A5A5A5A -> mem fields match exactly and data_data_ok fires on mem_data_ok.
REQ-044 Busy stall: inst_req raised while in WAIT_D -> mem_req stays 0 until IDLE, and inst is served next without being lost.
REQ-045 Spurious mem_data_ok asserted in IDLE or ADDR_I -> no data_ok pulse and no state change.
REQ-046 Reset asserted in WAIT_I -> outputs 0 immediately; after release, a fresh data_req completes normally.
